// File: rtl/bus_uart_periph.sv
// Memory-mapped 8N1 UART: TX byte register, RX FIFO, sticky status and RX interrupt
// in a 16-byte bus window with registered read data.
module bus_uart_periph #(
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       DATA_W       = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 'h9000,
  parameter int unsigned       CLKS_PER_BIT = 434,
  parameter int unsigned       RX_DEPTH     = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              we_i,
  input  logic              rd_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              irq_o,
  input  logic              uart_rx_i,
  output logic              uart_tx_o
);
  localparam int unsigned PTR_W = $clog2(RX_DEPTH);
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  logic       hit;
  logic [1:0] offset;
  logic       wr_tx, wr_stat, wr_ctrl, rd_rx;
  logic       unused_bits;

  assign hit         = address_i[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4];
  assign offset      = address_i[3:2];
  assign wr_tx       = we_i & hit & (offset == 2'd0);
  assign wr_stat     = we_i & hit & (offset == 2'd2);
  assign wr_ctrl     = we_i & hit & (offset == 2'd3);
  assign rd_rx       = rd_i & hit & (offset == 2'd1);
  assign unused_bits = ^{address_i[1:0], data_i};

  // ---------------- TX ----------------
  uart_state_e      tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_busy;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    uart_tx_o  = 1'b1;
    case (tx_state_q)
      S_IDLE: begin
        if (wr_tx) begin
          tx_state_d = S_START;
          tx_cnt_d   = '0;
          tx_shift_d = data_i[7:0];
        end
      end
      S_START: begin
        uart_tx_o = 1'b0;
        if (tx_cnt_q == LAST) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
        end else tx_cnt_d = tx_cnt_q + CNT_W'(1);
      end
      S_DATA: begin
        uart_tx_o = tx_shift_q[0];
        if (tx_cnt_q == LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
          else tx_bit_d = tx_bit_q + 3'd1;
        end else tx_cnt_d = tx_cnt_q + CNT_W'(1);
      end
      S_STOP: begin
        if (tx_cnt_q == LAST) begin
          tx_state_d = S_IDLE;
          tx_cnt_d   = '0;
        end else tx_cnt_d = tx_cnt_q + CNT_W'(1);
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  assign tx_busy = tx_state_q != S_IDLE;

  // ---------------- RX ----------------
  uart_state_e      rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [1:0]       rx_sync_q;
  logic             rx_prev_q, rx_s, rx_push, rx_ferr;

  assign rx_s = rx_sync_q[1];

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rx_sync_q  <= '1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], uart_rx_i};
      rx_prev_q  <= rx_s;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_prev_q & ~rx_s) begin
          rx_state_d = S_START;
          rx_cnt_d   = '0;
        end
      end
      S_START: begin
        // mid-bit re-check rejects short low glitches
        if (rx_cnt_q == HALF) begin
          if (rx_s) rx_state_d = S_IDLE;
          else begin
            rx_state_d = S_DATA;
            rx_cnt_d   = '0;
            rx_bit_d   = '0;
          end
        end else rx_cnt_d = rx_cnt_q + CNT_W'(1);
      end
      S_DATA: begin
        if (rx_cnt_q == LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else rx_bit_d = rx_bit_q + 3'd1;
        end else rx_cnt_d = rx_cnt_q + CNT_W'(1);
      end
      S_STOP: begin
        if (rx_cnt_q == LAST) begin
          rx_push    = rx_s;
          rx_ferr    = ~rx_s;
          rx_state_d = S_IDLE;
          rx_cnt_d   = '0;
        end else rx_cnt_d = rx_cnt_q + CNT_W'(1);
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // ---------------- FIFO, status, bus ----------------
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   rx_count_q;
  logic             full, nonempty, pop, push_ok, ovr_set;
  logic             overrun_q, frame_err_q, irq_en_q;
  logic [DATA_W-1:0] rd_val;

  assign full     = rx_count_q == (PTR_W+1)'(RX_DEPTH);
  assign nonempty = rx_count_q != '0;
  assign pop      = rd_rx & nonempty;
  assign push_ok  = rx_push & (~full | pop);
  assign ovr_set  = rx_push & full & ~pop;

  always_ff @(posedge clk_i) begin
    if (push_ok) rx_mem[wr_ptr_q] <= rx_shift_q;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rx_count_q  <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      irq_en_q    <= 1'b0;
      rd_data_o   <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   rx_count_q <= rx_count_q + (PTR_W+1)'(1);
        2'b01:   rx_count_q <= rx_count_q - (PTR_W+1)'(1);
        default: rx_count_q <= rx_count_q;
      endcase
      if (ovr_set)                     overrun_q <= 1'b1;
      else if (wr_stat && data_i[3])   overrun_q <= 1'b0;
      if (rx_ferr)                     frame_err_q <= 1'b1;
      else if (wr_stat && data_i[4])   frame_err_q <= 1'b0;
      if (wr_ctrl) irq_en_q <= data_i[0];
      if (rd_i)    rd_data_o <= rd_val;
    end
  end

  always_comb begin
    rd_val = '0;
    if (hit) begin
      case (offset)
        2'd1:    if (nonempty) rd_val[7:0] = rx_mem[rd_ptr_q];
        2'd2:    rd_val[4:0] = {frame_err_q, overrun_q, full, nonempty, tx_busy};
        2'd3:    rd_val[0] = irq_en_q;
        default: rd_val = '0;
      endcase
    end
  end

  assign irq_o = irq_en_q & nonempty;
endmodule

// File: tb/tb_bus_uart_periph.sv
// Directed bench for bus_uart_periph: register vector table plus TX/RX/FIFO/IRQ/reset sequences.
module tb_bus_uart_periph;
  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] address, wdata, rd_data;
  logic        we, rd, irq, rx, tx;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  bus_uart_periph #(
    .ADDR_W(32), .DATA_W(32), .BASE_ADDR(32'h9000), .CLKS_PER_BIT(CPB), .RX_DEPTH(4)
  ) dut (
    .clk_i(clk), .reset_i(reset_n), .address_i(address), .we_i(we), .rd_i(rd),
    .data_i(wdata), .rd_data_o(rd_data), .irq_o(irq), .uart_rx_i(rx), .uart_tx_o(tx)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic        rd;
    logic [31:0] wd;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; wdata = d; we = 1'b1; rd = 1'b0;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    address = a; rd = 1'b1; we = 1'b0;
    @(posedge clk);
    #1 check(name, rd_data, exp);
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      repeat (CPB) begin
        @(negedge clk);
        rx = bits[i];
      end
    end
    @(negedge clk);
    rx = 1'b1;
    idle(3);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] txpat;
    logic       exp_bit;
    txpat = 8'hA5;
    reset_n = 1'b0; address = '0; wdata = '0; we = 1'b0; rd = 1'b0; rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rd_data", rd_data, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    check("reset_tx", {31'h0, tx}, 32'h1);
    @(negedge clk);
    reset_n = 1'b1;

    // addr, we, rd, wdata, expected rd_data after the edge
    vecs[0]  = '{32'h900C, 1'b1, 1'b0, 32'h1, 32'h0};
    vecs[1]  = '{32'h900C, 1'b0, 1'b1, 32'h0, 32'h1};
    vecs[2]  = '{32'h0000, 1'b0, 1'b0, 32'h0, 32'h1};
    vecs[3]  = '{32'h9008, 1'b0, 1'b1, 32'h0, 32'h0};
    vecs[4]  = '{32'h9000, 1'b0, 1'b1, 32'h0, 32'h0};
    vecs[5]  = '{32'hA00C, 1'b1, 1'b0, 32'h0, 32'h0};
    vecs[6]  = '{32'h900C, 1'b0, 1'b1, 32'h0, 32'h1};
    vecs[7]  = '{32'hA00C, 1'b0, 1'b1, 32'h0, 32'h0};
    vecs[8]  = '{32'h9004, 1'b0, 1'b1, 32'h0, 32'h0};
    vecs[9]  = '{32'h900C, 1'b1, 1'b1, 32'h0, 32'h1};
    vecs[10] = '{32'h900C, 1'b0, 1'b1, 32'h0, 32'h0};
    vecs[11] = '{32'h900C, 1'b1, 1'b0, 32'h1, 32'h0};
    vecs[12] = '{32'h900C, 1'b0, 1'b1, 32'h0, 32'h1};
    vecs[13] = '{32'h9010, 1'b0, 1'b1, 32'h0, 32'h0};
    vecs[14] = '{32'h900C, 1'b0, 1'b1, 32'h0, 32'h1};
    vecs[15] = '{32'h8FFC, 1'b0, 1'b1, 32'h0, 32'h0};
    vecs[16] = '{32'h900C, 1'b1, 1'b1, 32'h0, 32'h1};
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      address = vecs[i].addr; we = vecs[i].we; rd = vecs[i].rd; wdata = vecs[i].wd;
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), rd_data, vecs[i].exp_rd);
    end
    @(negedge clk);
    we = 1'b0; rd = 1'b0;
    check("irq_idle", {31'h0, irq}, 32'h0);

    // TX frame 0xA5, second write mid-frame, STATUS read mid-frame
    @(negedge clk);
    address = 32'h9000; wdata = 32'hA5; we = 1'b1;
    @(posedge clk);
    #1 we = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (k < 8) exp_bit = 1'b0;
      else if (k < 72) exp_bit = txpat[(k - 8) / 8];
      else exp_bit = 1'b1;
      check($sformatf("tx_bit_cyc%0d", k), {31'h0, tx}, {31'h0, exp_bit});
      if (k == 41) check("tx_busy_mid", rd_data, 32'h1);
      we = 1'b0; rd = 1'b0;
      if (k == 20) begin address = 32'h9000; wdata = 32'h00; we = 1'b1; end
      if (k == 40) begin address = 32'h9008; rd = 1'b1; end
      @(posedge clk);
      #1;
    end
    check("tx_idle_after", {31'h0, tx}, 32'h1);
    read_check("tx_busy_done", 32'h9008, 32'h0);

    // single RX frame
    send_frame(8'h3C, 1'b1);
    read_check("rx_status", 32'h9008, 32'h2);
    read_check("rx_data", 32'h9004, 32'h3C);
    read_check("rx_status_empty", 32'h9008, 32'h0);
    read_check("rx_data_empty", 32'h9004, 32'h0);

    // overrun: five frames into a 4-deep FIFO
    for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
    read_check("ovr_status", 32'h9008, 32'hE);
    for (int b = 1; b <= 4; b++) read_check($sformatf("ovr_data%0d", b), 32'h9004, b);
    read_check("ovr_sticky", 32'h9008, 32'h8);
    bus_write(32'h9008, 32'h8);
    read_check("ovr_cleared", 32'h9008, 32'h0);

    // framing error and glitch rejection
    send_frame(8'h77, 1'b0);
    read_check("ferr_status", 32'h9008, 32'h10);
    read_check("ferr_no_data", 32'h9004, 32'h0);
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    idle(100);
    read_check("glitch_status", 32'h9008, 32'h10);
    bus_write(32'h9008, 32'h10);
    read_check("ferr_cleared", 32'h9008, 32'h0);

    // interrupt
    bus_write(32'h900C, 32'h1);
    check("irq_en_empty", {31'h0, irq}, 32'h0);
    send_frame(8'h10, 1'b1);
    check("irq_pending", {31'h0, irq}, 32'h1);
    read_check("irq_data", 32'h9004, 32'h10);
    check("irq_after_pop", {31'h0, irq}, 32'h0);
    bus_write(32'h900C, 32'h0);
    send_frame(8'h20, 1'b1);
    check("irq_disabled", {31'h0, irq}, 32'h0);
    read_check("irq_dis_status", 32'h9008, 32'h2);
    read_check("irq_dis_data", 32'h9004, 32'h20);

    // reset in the middle of TX and RX frames
    bus_write(32'h900C, 32'h1);
    send_frame(8'h11, 1'b1);
    check("pre_reset_irq", {31'h0, irq}, 32'h1);
    bus_write(32'h9000, 32'h5A);
    idle(10);
    read_check("pre_reset_ctrl", 32'h900C, 32'h1);
    @(negedge clk);
    rx = 1'b0;
    repeat (12) @(negedge clk);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("mid_reset_tx", {31'h0, tx}, 32'h1);
    check("mid_reset_irq", {31'h0, irq}, 32'h0);
    check("mid_reset_rd_data", rd_data, 32'h0);
    rx = 1'b1;
    idle(2);
    reset_n = 1'b1;
    read_check("post_reset_status", 32'h9008, 32'h0);
    read_check("post_reset_ctrl", 32'h900C, 32'h0);
    send_frame(8'hC3, 1'b1);
    read_check("post_reset_rx_status", 32'h9008, 32'h2);
    read_check("post_reset_rx_data", 32'h9004, 32'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
